// File: rtl/grayscale_pipe.sv
// grayscale_pipe
//   RGB-to-grayscale stage between the input pixel FIFO and the sobel line
//   buffer. It is a 3-stage, one-pixel-per-cycle pipeline. The conversion mode
//   is chosen per pixel and travels down the pipe with that pixel. When the
//   output FIFO is full and S3 holds a pixel, every stage stalls together, so
//   no pixel is lost or repeated.
//
//   Stages:
//     S1 - capture {R,G,B,mode} from the FWFT input FIFO
//     S2 - weighted sum (modes 1/2), plain sum (mode 0) or max (mode 3)
//     S3 - final shift or divide-by-3, registered onto fifo_out_din
//
// Ports
//   clock, reset     rising-edge clock, synchronous active-high reset
//   mode             0 avg, 1 BT.601, 2 BT.709, 3 max-of-RGB (sampled with pixel)
//   fifo_in_rd_en    pop input FIFO (combinational)
//   fifo_in_dout     {R,G,B}, R in the MSBs
//   fifo_in_empty    input FIFO empty
//   fifo_out_wr_en   push output FIFO (combinational)
//   fifo_out_din     registered gray, replicated to {g,g,g} when REPLICATE=1
//   fifo_out_full    output FIFO full
//   busy             any stage holds a pixel
//   pixel_count      pixels written since reset (wraps)
module grayscale_pipe #(
  parameter int COMP_WIDTH = 8,
  parameter int REPLICATE  = 0,
  parameter int CNT_WIDTH  = 32,
  localparam int DOUT_W    = COMP_WIDTH * ((REPLICATE != 0) ? 3 : 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              mode,
  output logic                    fifo_in_rd_en,
  input  logic [3*COMP_WIDTH-1:0] fifo_in_dout,
  input  logic                    fifo_in_empty,
  output logic                    fifo_out_wr_en,
  output logic [DOUT_W-1:0]       fifo_out_din,
  input  logic                    fifo_out_full,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    pixel_count
);

  localparam int W      = COMP_WIDTH;
  localparam int AW     = W + 9;   // 255*256+128 fits; so does 3*(2^W-1)
  localparam int STAGES = 3;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] g;
    logic [W-1:0] b;
    logic [1:0]   mode;
  } s1_t;

  logic [STAGES:1] vld_pipe;
  logic            vld_in;
  logic            advance;

  s1_t             s1;
  logic [AW-1:0]   s2_acc, s2_acc_d;
  logic [1:0]      s2_mode;
  logic [W-1:0]    gray, gray_d;

  // A stall is needed only when S3 has a pixel the output FIFO can't take.
  // Bubbles in S3 never block, so an empty slot is squeezed out even when full.
  assign advance        = !(vld_pipe[STAGES] && fifo_out_full);
  assign vld_in         = !reset && !fifo_in_empty && advance;
  assign fifo_in_rd_en  = vld_in;
  assign fifo_out_wr_en = !reset && vld_pipe[STAGES] && !fifo_out_full;
  assign busy           = |vld_pipe;

  // S2 datapath: all operands zero-extended to AW so no product overflows.
  logic [AW-1:0] r_e, g_e, b_e;
  logic [W-1:0]  mx;

  assign r_e = AW'(s1.r);
  assign g_e = AW'(s1.g);
  assign b_e = AW'(s1.b);

  always_comb begin
    mx = s1.r;
    if (s1.g > mx) mx = s1.g;
    if (s1.b > mx) mx = s1.b;
  end

  always_comb begin
    s2_acc_d = '0;
    case (s1.mode)
      2'd0:    s2_acc_d = r_e + g_e + b_e;
      2'd1:    s2_acc_d = AW'(77) * r_e + AW'(150) * g_e + AW'(29) * b_e + AW'(128);
      2'd2:    s2_acc_d = AW'(54) * r_e + AW'(183) * g_e + AW'(19) * b_e + AW'(128);
      default: s2_acc_d = AW'(mx);
    endcase
  end

  // S3 datapath. Divide by a constant 3 is exact; the quotient of a sum
  // below 3*2^W always fits in W bits. Weights sum to 256, so >>8 cannot overflow.
  always_comb begin
    gray_d = '0;
    case (s2_mode)
      2'd0:    gray_d = W'(s2_acc / AW'(3));
      2'd1,
      2'd2:    gray_d = s2_acc[W+7:8];
      default: gray_d = s2_acc[W-1:0];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe    <= '0;
      s1          <= '0;
      s2_acc      <= '0;
      s2_mode     <= '0;
      gray        <= '0;
      pixel_count <= '0;
    end else begin
      if (advance) begin
        vld_pipe <= {vld_pipe[STAGES-1:1], vld_in};
        // Data regs load only behind a valid pixel so the output stays quiet on bubbles.
        if (vld_in) begin
          s1.r    <= fifo_in_dout[3*W-1:2*W];
          s1.g    <= fifo_in_dout[2*W-1:W];
          s1.b    <= fifo_in_dout[W-1:0];
          s1.mode <= mode;
        end
        if (vld_pipe[1]) begin
          s2_acc  <= s2_acc_d;
          s2_mode <= s1.mode;
        end
        if (vld_pipe[2]) gray <= gray_d;
      end
      if (fifo_out_wr_en) pixel_count <= pixel_count + CNT_WIDTH'(1);
    end
  end

  generate
    if (REPLICATE != 0) begin : g_rep
      assign fifo_out_din = {3{gray}};
    end else begin : g_mono
      assign fifo_out_din = gray;
    end
  endgenerate

endmodule

// File: tb/tb_grayscale_pipe.sv
// tb_grayscale_pipe
//   Directed and randomised bench for grayscale_pipe. It uses two instances:
//     dut   - defaults (8-bit components, mono output, 32-bit counter)
//     dut_b - COMP_WIDTH=10, REPLICATE=1, CNT_WIDTH=4 (replication, counter wrap)
//   Inputs change 1 time unit after the rising edge. Outputs are sampled on
//   the falling edge.
module tb_grayscale_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        fifo_in_rd_en;
  logic [23:0] fifo_in_dout;
  logic        fifo_in_empty;
  logic        fifo_out_wr_en;
  logic [7:0]  fifo_out_din;
  logic        fifo_out_full;
  logic        busy;
  logic [31:0] pixel_count;

  logic        b_reset;
  logic [1:0]  b_mode;
  logic        b_rd_en;
  logic [29:0] b_din_in;
  logic        b_empty;
  logic        b_wr_en;
  logic [29:0] b_dout;
  logic        b_full;
  logic        b_busy;
  logic [3:0]  b_count;

  always #5 clock = ~clock;

  grayscale_pipe dut (
    .clock(clock), .reset(reset), .mode(mode),
    .fifo_in_rd_en(fifo_in_rd_en), .fifo_in_dout(fifo_in_dout), .fifo_in_empty(fifo_in_empty),
    .fifo_out_wr_en(fifo_out_wr_en), .fifo_out_din(fifo_out_din), .fifo_out_full(fifo_out_full),
    .busy(busy), .pixel_count(pixel_count)
  );

  grayscale_pipe #(.COMP_WIDTH(10), .REPLICATE(1), .CNT_WIDTH(4)) dut_b (
    .clock(clock), .reset(b_reset), .mode(b_mode),
    .fifo_in_rd_en(b_rd_en), .fifo_in_dout(b_din_in), .fifo_in_empty(b_empty),
    .fifo_out_wr_en(b_wr_en), .fifo_out_din(b_dout), .fifo_out_full(b_full),
    .busy(b_busy), .pixel_count(b_count)
  );

  int checks = 0;
  int errors = 0;

  // Each pixel is stored as {R,G,B,mode}.
  logic [25:0] q_in[$];
  logic [7:0]  q_exp[$];
  bit          hold_empty = 0;
  bit          force_full = 0;
  int          cyc = 0;
  int          nwr = 0;
  int          first_wr = 0;
  int          last_wr = 0;
  logic        last_rd, last_wr_en, last_busy;

  function automatic logic [7:0] model(input logic [25:0] p);
    int r, g, b, v;
    r = int'(p[25:18]);
    g = int'(p[17:10]);
    b = int'(p[9:2]);
    case (p[1:0])
      2'd0:    v = (r + g + b) / 3;
      2'd1:    v = (77 * r + 150 * g + 29 * b + 128) / 256;
      2'd2:    v = (54 * r + 183 * g + 19 * b + 128) / 256;
      default: begin
        v = r;
        if (g > v) v = g;
        if (b > v) v = b;
      end
    endcase
    return 8'(v);
  endfunction

  task automatic drive();
    fifo_in_empty = hold_empty || (q_in.size() == 0);
    if (q_in.size() > 0) {fifo_in_dout, mode} = q_in[0];
    fifo_out_full = force_full;
  endtask

  // One clock of the streaming framework. It checks any write against the
  // scoreboard, models the pop, and then drives the next inputs.
  task automatic cycle();
    logic [7:0] exp;
    bit popped;
    @(negedge clock);
    last_rd    = fifo_in_rd_en;
    last_wr_en = fifo_out_wr_en;
    last_busy  = busy;
    if (fifo_out_wr_en) begin
      checks++;
      if (fifo_out_full) begin
        errors++;
        $display("FAIL wr_while_full: wr_en=1 with full=1 at cycle %0d", cyc);
      end else if (q_exp.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wr: got %h, expected no write", fifo_out_din);
      end else begin
        exp = q_exp.pop_front();
        if (fifo_out_din !== exp) begin
          errors++;
          $display("FAIL stream_data: got %h expected %h", fifo_out_din, exp);
        end
      end
      if (nwr == 0) first_wr = cyc;
      last_wr = cyc;
      nwr++;
    end
    popped = fifo_in_rd_en;
    @(posedge clock); #1;
    cyc++;
    if (popped) begin
      if (q_in.size() == 0) begin
        errors++;
        $display("FAIL pop_empty: rd_en=1 got, expected 0 with no data");
      end else begin
        q_exp.push_back(model(q_in[0]));
        void'(q_in.pop_front());
      end
    end
    drive();
  endtask

  task automatic drain(input int bound);
    int n = 0;
    hold_empty = 0;
    force_full = 0;
    drive();
    while ((q_in.size() != 0 || q_exp.size() != 0 || busy) && n < bound) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL drain_timeout: got %0d left, expected 0", q_exp.size() + q_in.size());
    end
  endtask

  task automatic test_reset();
    reset = 1; fifo_in_empty = 0; fifo_in_dout = 24'h102030; mode = 0; fifo_out_full = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks += 5;
    if (fifo_in_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b expected 0", fifo_in_rd_en); end
    if (fifo_out_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b expected 0", fifo_out_wr_en); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (fifo_out_din !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h expected 00", fifo_out_din); end
    if (pixel_count !== 32'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", pixel_count); end
    @(posedge clock); #1;
    reset = 0; fifo_in_empty = 1;
  endtask

  // One pixel at a time, so latency and values are checked in isolation.
  task automatic test_directed();
    logic [25:0] px [8];
    logic [7:0]  ex [8];
    logic [7:0]  val;
    int lat;
    bit got;
    px[0] = {24'h102030, 2'd0}; ex[0] = 8'h20;
    px[1] = {24'hFF0000, 2'd0}; ex[1] = 8'h55;
    px[2] = {24'hFFFFFF, 2'd0}; ex[2] = 8'hFF;
    px[3] = {24'h102030, 2'd1}; ex[3] = 8'h1D;
    px[4] = {24'h102030, 2'd2}; ex[4] = 8'h1E;
    px[5] = {24'h102030, 2'd3}; ex[5] = 8'h30;
    px[6] = {24'hFFFFFF, 2'd1}; ex[6] = 8'hFF;
    px[7] = {24'hFFFFFF, 2'd2}; ex[7] = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      fifo_in_empty = 0;
      {fifo_in_dout, mode} = px[i];
      @(negedge clock);
      checks++;
      if (fifo_in_rd_en !== 1'b1) begin errors++; $display("FAIL dir_rd_en[%0d]: got %b expected 1", i, fifo_in_rd_en); end
      @(posedge clock); #1;
      fifo_in_empty = 1;
      got = 0; lat = 0; val = '0;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clock);
        if (fifo_out_wr_en) begin got = 1; lat = c; val = fifo_out_din; end
        @(posedge clock); #1;
        if (got) break;
      end
      checks += 3;
      if (lat != 3) begin errors++; $display("FAIL dir_latency[%0d]: got %0d expected 3", i, lat); end
      if (val !== ex[i]) begin errors++; $display("FAIL dir_value[%0d]: got %h expected %h", i, val, ex[i]); end
      if (pixel_count !== 32'(i + 1)) begin errors++; $display("FAIL dir_count[%0d]: got %0d expected %0d", i, pixel_count, i + 1); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) q_in.push_back({8'(i * 21), 8'(255 - i * 7), 8'(i * 13 + 5), 2'(i)});
    nwr = 0;
    drain(60);
    checks += 2;
    if (nwr != 12) begin errors++; $display("FAIL b2b_count: got %0d expected 12", nwr); end
    if (last_wr - first_wr != 11) begin errors++; $display("FAIL b2b_span: got %0d expected 11", last_wr - first_wr); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 10; i++) q_in.push_back({8'(i * 25), 8'(i * 3), 8'(200 - i * 9), 2'(3 - (i % 4))});
    nwr = 0;
    hold_empty = 0; force_full = 0;
    drive();
    repeat (3) cycle();
    force_full = 1;
    drive();
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks += 3;
      if (last_wr_en !== 1'b0) begin errors++; $display("FAIL stall_wr[%0d]: got %b expected 0", i, last_wr_en); end
      if (last_rd !== 1'b0) begin errors++; $display("FAIL stall_rd[%0d]: got %b expected 0", i, last_rd); end
      if (last_busy !== 1'b1) begin errors++; $display("FAIL stall_busy[%0d]: got %b expected 1", i, last_busy); end
    end
    force_full = 0;
    drive();
    cycle();
    checks++;
    if (last_wr_en !== 1'b1) begin errors++; $display("FAIL stall_release_wr: got %b expected 1", last_wr_en); end
    drain(60);
    checks++;
    if (nwr != 10) begin errors++; $display("FAIL stall_total: got %0d expected 10", nwr); end
  endtask

  task automatic test_random();
    logic [31:0] base;
    int n = 0;
    base = pixel_count;
    nwr = 0;
    for (int i = 0; i < 1000; i++)
      q_in.push_back({8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom)});
    while (q_in.size() != 0 && n < 20000) begin
      hold_empty = ($urandom_range(0, 2) == 0);
      force_full = ($urandom_range(0, 3) == 0);
      drive();
      cycle();
      n++;
    end
    drain(200);
    checks += 2;
    if (nwr != 1000) begin errors++; $display("FAIL rand_writes: got %0d expected 1000", nwr); end
    if (pixel_count - base !== 32'd1000) begin errors++; $display("FAIL rand_count: got %0d expected 1000", pixel_count - base); end
  endtask

  task automatic test_reset_midstream();
    bit p;
    for (int i = 0; i < 8; i++) q_in.push_back({8'(i * 30), 8'(i * 11), 8'(i * 2), 2'(i)});
    hold_empty = 0; force_full = 0;
    drive();
    repeat (3) cycle();
    reset = 1;
    @(negedge clock);
    checks += 2;
    if (fifo_out_wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr: got %b expected 0", fifo_out_wr_en); end
    if (fifo_in_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd: got %b expected 0", fifo_in_rd_en); end
    @(posedge clock); #1;
    reset = 0;
    q_exp.delete();
    drive();
    @(negedge clock);
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    if (pixel_count !== 32'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", pixel_count); end
    if (fifo_out_wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr2: got %b expected 0", fifo_out_wr_en); end
    if (fifo_in_rd_en !== 1'b1) begin errors++; $display("FAIL rstmid_first_pop: got %b expected 1", fifo_in_rd_en); end
    p = fifo_in_rd_en;
    @(posedge clock); #1;
    if (p) begin q_exp.push_back(model(q_in[0])); void'(q_in.pop_front()); end
    drive();
    nwr = 0;
    drain(60);
    checks += 2;
    if (nwr != 5) begin errors++; $display("FAIL rstmid_writes: got %0d expected 5", nwr); end
    if (pixel_count !== 32'd5) begin errors++; $display("FAIL rstmid_final_count: got %0d expected 5", pixel_count); end
  endtask

  task automatic test_replicate();
    int pops = 0;
    int n = 0;
    bit p, w;
    b_reset = 1;
    @(posedge clock); #1;
    b_reset = 0; b_mode = 2'd3; b_din_in = {10'h3FF, 10'h001, 10'h002}; b_empty = 0; b_full = 0;
    for (int c = 0; c < 60 && n < 17; c++) begin
      @(negedge clock);
      w = b_wr_en;
      if (w) begin
        n++;
        checks++;
        if (b_dout !== 30'h3FFF_FFFF) begin errors++; $display("FAIL rep_data: got %h expected 3fffffff", b_dout); end
      end
      p = b_rd_en;
      @(posedge clock); #1;
      if (p) pops++;
      if (pops >= 17) b_empty = 1;
      if (w) begin
        checks++;
        if (b_count !== 4'(n % 16)) begin errors++; $display("FAIL rep_count: got %0d expected %0d", b_count, n % 16); end
      end
    end
    checks++;
    if (n != 17) begin errors++; $display("FAIL rep_writes: got %0d expected 17", n); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    b_reset = 1; b_mode = 0; b_din_in = '0; b_empty = 1; b_full = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_midstream();
    test_replicate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
